// File: rtl/gps_emu_pkg.sv
// ---------------------------------------------------------------------------
// gps_emu_pkg
// Shared definitions for the gps_emulator host controller: register map
// address constants, controller state encoding and the per-satellite
// configuration record.
// ---------------------------------------------------------------------------
package gps_emu_pkg;

    // Per-satellite register offsets (wr_addr[3:0] when wr_addr[7:4] < NSAT)
    localparam logic [3:0] REG_FREQ   = 4'd0;
    localparam logic [3:0] REG_GAIN   = 4'd1;
    localparam logic [3:0] REG_CASEL  = 4'd2;
    localparam logic [3:0] REG_RATE   = 4'd3;

    // Global register block (wr_addr[7:4] == SAT_GLOBAL)
    localparam logic [3:0] SAT_GLOBAL = 4'hF;
    localparam logic [3:0] REG_CTRL   = 4'd0;
    localparam logic [3:0] REG_NOISE  = 4'd1;

    // CTRL register bit positions
    localparam int CTRL_RUN_BIT    = 0;
    localparam int CTRL_COMMIT_BIT = 1;

    // Highest valid C/A code select (PRN table has 36 entries)
    localparam logic [5:0] CA_SEL_MAX = 6'd35;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic [31:0] freq;
        logic [15:0] gain;
        logic [5:0]  ca_sel;
        logic [31:0] freq_rate;   // signed doppler increment per epoch
    } sat_cfg_t;

endpackage

// File: rtl/gps_epoch_timer.sv
// ---------------------------------------------------------------------------
// gps_epoch_timer
// Chip / code-epoch counter, cycle-aligned with the emulator C/A address
// wrap. Counters are held at zero while run is low, so every run starts a
// fresh epoch.
//   clk          in  system clock
//   rstn         in  asynchronous reset, active low
//   run          in  count enable; low clears both counters
//   epoch_pulse  out high on the last clk of each code epoch
// CHIP_CLKS and EPOCH_CHIPS must both be >= 2.
// ---------------------------------------------------------------------------
module gps_epoch_timer #(
    parameter int CHIP_CLKS   = 100,
    parameter int EPOCH_CHIPS = 1023
) (
    input  logic clk,
    input  logic rstn,
    input  logic run,
    output logic epoch_pulse
);

    localparam int CLK_W  = $clog2(CHIP_CLKS);
    localparam int CHIP_W = $clog2(EPOCH_CHIPS);
    localparam logic [CLK_W-1:0]  CLK_LAST  = CLK_W'(CHIP_CLKS - 1);
    localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(EPOCH_CHIPS - 1);

    logic [CLK_W-1:0]  clk_cnt_q,  clk_cnt_d;
    logic [CHIP_W-1:0] chip_cnt_q, chip_cnt_d;
    logic              chip_end;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        clk_cnt_d   = clk_cnt_q;
        chip_cnt_d  = chip_cnt_q;
        chip_end    = (clk_cnt_q == CLK_LAST);
        epoch_pulse = run && chip_end && (chip_cnt_q == CHIP_LAST);

        if (!run) begin
            clk_cnt_d  = '0;
            chip_cnt_d = '0;
        end else if (chip_end) begin
            clk_cnt_d  = '0;
            chip_cnt_d = (chip_cnt_q == CHIP_LAST) ? '0 : chip_cnt_q + 1'b1;
        end else begin
            clk_cnt_d  = clk_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state flops use non-blocking assignment so every flop samples
        // pre-edge values regardless of process ordering.
        if (!rstn) begin
            clk_cnt_q  <= '0;
            chip_cnt_q <= '0;
        end else begin
            clk_cnt_q  <= clk_cnt_d;
            chip_cnt_q <= chip_cnt_d;
        end
    end

endmodule

// File: rtl/gps_emu_ctrl.sv
// ---------------------------------------------------------------------------
// gps_emu_ctrl
// Host configuration and sequencing controller for the gps_emulator.
// Host writes land in shadow registers; a commit copies shadow to active
// at once in IDLE, or on the next code-epoch boundary while running.
// While running, each epoch adds the committed doppler rate to freq.
//   clk          in   system clock
//   rstn         in   asynchronous reset, active low
//   wr_valid     in   host write request
//   wr_ready     out  host write accept (low while a commit is pending)
//   wr_addr      in   [7:4] sat index (0xF = global), [3:0] register
//   wr_data      in   write data
//   wr_err       out  1-cycle pulse after an accepted write was dropped
//   enable       out  emulator enable
//   freq         out  [NSAT] active doppler word
//   gain         out  [NSAT] active gain
//   ca_sel       out  [NSAT] active C/A select
//   noise_gain   out  active noise gain
//   epoch_pulse  out  high on the last clk of each code epoch
//   epoch_count  out  epochs completed since run start (wraps)
//   commit_pend  out  a commit is waiting for an epoch boundary
// ---------------------------------------------------------------------------
module gps_emu_ctrl
    import gps_emu_pkg::*;
#(
    parameter int NSAT        = 4,
    parameter int CHIP_CLKS   = 100,
    parameter int EPOCH_CHIPS = 1023
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_err,
    output logic        enable,
    output logic [31:0] freq   [NSAT],
    output logic [15:0] gain   [NSAT],
    output logic [5:0]  ca_sel [NSAT],
    output logic [15:0] noise_gain,
    output logic        epoch_pulse,
    output logic [31:0] epoch_count,
    output logic        commit_pend
);

    localparam logic [4:0] NSAT_LIM = 5'(NSAT);

    ctrl_state_t state_q, state_d;
    sat_cfg_t    shadow_q [NSAT];
    sat_cfg_t    shadow_d [NSAT];
    sat_cfg_t    active_q [NSAT];
    sat_cfg_t    active_d [NSAT];
    logic [15:0] noise_sh_q, noise_sh_d;
    logic [15:0] noise_act_q, noise_act_d;
    logic        enable_q, enable_d;
    logic        wr_err_q, wr_err_d;
    logic [31:0] epoch_count_q, epoch_count_d;

    logic        wr_fire;
    logic [3:0]  sat_idx;
    logic [3:0]  reg_idx;
    logic        ctrl_wr;
    logic        ctrl_run;
    logic        ctrl_commit;
    logic        do_commit;
    logic        do_ramp;

    gps_epoch_timer #(
        .CHIP_CLKS   (CHIP_CLKS),
        .EPOCH_CHIPS (EPOCH_CHIPS)
    ) u_timer (
        .clk         (clk),
        .rstn        (rstn),
        .run         (enable_q),
        .epoch_pulse (epoch_pulse)
    );

    assign wr_ready    = (state_q != PEND);
    assign commit_pend = (state_q == PEND);
    assign wr_fire     = wr_valid && wr_ready;
    assign sat_idx     = wr_addr[7:4];
    assign reg_idx     = wr_addr[3:0];
    assign ctrl_run    = wr_data[CTRL_RUN_BIT];
    assign ctrl_commit = wr_data[CTRL_COMMIT_BIT];

    // Write decode into the shadow registers
    always_comb begin
        shadow_d   = shadow_q;
        noise_sh_d = noise_sh_q;
        wr_err_d   = 1'b0;
        ctrl_wr    = 1'b0;

        if (wr_fire) begin
            if (sat_idx == SAT_GLOBAL) begin
                unique case (reg_idx)
                    REG_CTRL:  ctrl_wr    = 1'b1;
                    REG_NOISE: noise_sh_d = wr_data[15:0];
                    default:   wr_err_d   = 1'b1;
                endcase
            end else if ({1'b0, sat_idx} < NSAT_LIM) begin
                for (int i = 0; i < NSAT; i++) begin
                    if (sat_idx == 4'(i)) begin
                        unique case (reg_idx)
                            REG_FREQ: shadow_d[i].freq = wr_data;
                            REG_GAIN: shadow_d[i].gain = wr_data[15:0];
                            REG_CASEL: begin
                                if (wr_data[5:0] > CA_SEL_MAX) wr_err_d = 1'b1;
                                else shadow_d[i].ca_sel = wr_data[5:0];
                            end
                            REG_RATE: shadow_d[i].freq_rate = wr_data;
                            default:  wr_err_d = 1'b1;
                        endcase
                    end
                end
            end else begin
                wr_err_d = 1'b1;
            end
        end
    end

    // Sequencing FSM, commit and doppler ramp
    always_comb begin
        state_d       = state_q;
        enable_d      = enable_q;
        epoch_count_d = epoch_count_q;
        active_d      = active_q;
        noise_act_d   = noise_act_q;
        do_commit     = 1'b0;
        do_ramp       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ctrl_wr) begin
                    do_commit = ctrl_commit;
                    if (ctrl_run) begin
                        state_d       = RUN;
                        enable_d      = 1'b1;
                        epoch_count_d = '0;
                    end
                end
            end
            RUN: begin
                if (epoch_pulse) begin
                    epoch_count_d = epoch_count_q + 32'd1;
                    do_ramp       = 1'b1;
                end
                if (ctrl_wr) begin
                    if (!ctrl_run) begin
                        state_d   = IDLE;
                        enable_d  = 1'b0;
                        do_commit = ctrl_commit;
                    end else if (ctrl_commit) begin
                        // A commit landing on the pulse clk waits a full epoch.
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (epoch_pulse) begin
                    epoch_count_d = epoch_count_q + 32'd1;
                    do_commit     = 1'b1;
                    state_d       = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        // A commit loads freq as written; the ramp is skipped that epoch.
        if (do_commit) begin
            active_d    = shadow_q;
            noise_act_d = noise_sh_q;
        end else if (do_ramp) begin
            for (int i = 0; i < NSAT; i++) begin
                active_d[i].freq = active_q[i].freq + active_q[i].freq_rate;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            enable_q      <= 1'b0;
            wr_err_q      <= 1'b0;
            epoch_count_q <= '0;
            noise_sh_q    <= '0;
            noise_act_q   <= '0;
            // NOTE: the register arrays are reset too; software relies on
            // shadow reading as zero after reset, not on leftover values.
            shadow_q      <= '{default: '0};
            active_q      <= '{default: '0};
        end else begin
            state_q       <= state_d;
            enable_q      <= enable_d;
            wr_err_q      <= wr_err_d;
            epoch_count_q <= epoch_count_d;
            noise_sh_q    <= noise_sh_d;
            noise_act_q   <= noise_act_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NSAT; i++) begin
            freq[i]   = active_q[i].freq;
            gain[i]   = active_q[i].gain;
            ca_sel[i] = active_q[i].ca_sel;
        end
    end

    assign enable      = enable_q;
    assign wr_err      = wr_err_q;
    assign noise_gain  = noise_act_q;
    assign epoch_count = epoch_count_q;

endmodule

// File: tb/tb_gps_emu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gps_emu_ctrl
// Directed bench for gps_emu_ctrl with a shortened epoch (10 clks/chip,
// 7 chips/epoch) so the whole run stays in a few hundred cycles.
// ---------------------------------------------------------------------------
module tb_gps_emu_ctrl;

    localparam int NSAT        = 4;
    localparam int CHIP_CLKS   = 10;
    localparam int EPOCH_CHIPS = 7;
    localparam int EPOCH_CLKS  = CHIP_CLKS * EPOCH_CHIPS;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_addr = 8'd0;
    logic [31:0] wr_data = 32'd0;
    logic        wr_err;
    logic        enable;
    logic [31:0] freq   [NSAT];
    logic [15:0] gain   [NSAT];
    logic [5:0]  ca_sel [NSAT];
    logic [15:0] noise_gain;
    logic        epoch_pulse;
    logic [31:0] epoch_count;
    logic        commit_pend;

    int total = 0;
    int bad   = 0;

    gps_emu_ctrl #(
        .NSAT        (NSAT),
        .CHIP_CLKS   (CHIP_CLKS),
        .EPOCH_CHIPS (EPOCH_CHIPS)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_err      (wr_err),
        .enable      (enable),
        .freq        (freq),
        .gain        (gain),
        .ca_sel      (ca_sel),
        .noise_gain  (noise_gain),
        .epoch_pulse (epoch_pulse),
        .epoch_count (epoch_count),
        .commit_pend (commit_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after a posedge; returns 1 time unit after the
    // handshake edge, so shadow and wr_err reflect the write.
    task automatic host_write(input logic [7:0] addr, input logic [31:0] data);
        int n = 0;
        while (!wr_ready && n < 4 * EPOCH_CLKS) begin
            @(posedge clk); #1;
            n++;
        end
        if (!wr_ready) check("wr_ready_timeout", {63'd0, wr_ready}, 64'd1);
        wr_addr  = addr;
        wr_data  = data;
        wr_valid = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    // Samples one full epoch worth of cycles starting at the current one.
    task automatic watch_epoch(output int pulses, output int first_k);
        pulses  = 0;
        first_k = 0;
        for (int k = 1; k <= EPOCH_CLKS; k++) begin
            if (epoch_pulse) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int   pulses;
        int   first_k;
        int   n;
        logic bp_ok;

        // ---- reset values
        #12;
        check("rst_enable",      {63'd0, enable},      64'd0);
        check("rst_wr_ready",    {63'd0, wr_ready},    64'd1);
        check("rst_commit_pend", {63'd0, commit_pend}, 64'd0);
        check("rst_wr_err",      {63'd0, wr_err},      64'd0);
        check("rst_freq0",       {32'd0, freq[0]},     64'd0);
        check("rst_epoch_count", {32'd0, epoch_count}, 64'd0);
        check("rst_noise",       {48'd0, noise_gain},  64'd0);
        #5 rstn = 1'b1;
        @(posedge clk); #1;

        // ---- commit in IDLE applies on the next clk
        host_write(8'h00, 32'h0000_1000);
        check("idle_freq0_shadow_only", {32'd0, freq[0]}, 64'd0);
        host_write(8'hF0, 32'h2);
        check("idle_commit_freq0", {32'd0, freq[0]},     64'h1000);
        check("idle_enable_low",   {63'd0, enable},      64'd0);
        check("idle_no_pend",      {63'd0, commit_pend}, 64'd0);

        // ---- run+commit from IDLE; first epoch uses new config
        host_write(8'h20, 32'd3);
        host_write(8'h23, 32'hFFFF_FFFB);          // -5
        host_write(8'hF0, 32'h3);
        check("run_enable",   {63'd0, enable},      64'd1);
        check("run_freq2",    {32'd0, freq[2]},     64'd3);
        check("run_ep_clear", {32'd0, epoch_count}, 64'd0);
        watch_epoch(pulses, first_k);
        check("ep1_pulse_count", 64'(pulses),       64'd1);
        check("ep1_pulse_clk",   64'(first_k),      64'(EPOCH_CLKS));
        check("ep1_count",       {32'd0, epoch_count}, 64'd1);
        check("ep1_freq2_ramp",  {32'd0, freq[2]},  64'hFFFF_FFFE);
        check("ep1_freq0_flat",  {32'd0, freq[0]},  64'h1000);
        watch_epoch(pulses, first_k);
        check("ep2_pulse_clk",   64'(first_k),      64'(EPOCH_CLKS));
        check("ep2_count",       {32'd0, epoch_count}, 64'd2);
        check("ep2_freq2_ramp",  {32'd0, freq[2]},  64'hFFFF_FFF9);

        // ---- commit in RUN waits for the epoch boundary
        host_write(8'h11, 32'h0000_4000);
        host_write(8'hF0, 32'h3);
        check("pend_set",      {63'd0, commit_pend}, 64'd1);
        check("pend_backpres", {63'd0, wr_ready},    64'd0);
        n     = 0;
        bp_ok = 1'b1;
        while (!epoch_pulse && n < 2 * EPOCH_CLKS) begin
            if (wr_ready !== 1'b0 || commit_pend !== 1'b1 || gain[1] !== 16'd0) bp_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check("pend_pulse_reached", {63'd0, epoch_pulse}, 64'd1);
        check("pend_held",          {63'd0, bp_ok},       64'd1);
        check("pend_gain1_on_pulse", {48'd0, gain[1]},    64'd0);
        @(posedge clk); #1;
        check("commit_gain1",      {48'd0, gain[1]},     64'h4000);
        check("commit_pend_clear", {63'd0, commit_pend}, 64'd0);
        check("commit_wr_ready",   {63'd0, wr_ready},    64'd1);
        check("commit_ep_count",   {32'd0, epoch_count}, 64'd3);
        check("commit_freq2_load", {32'd0, freq[2]},     64'd3);

        // ---- stop, then dropped writes
        host_write(8'hF0, 32'h0);
        check("stop_enable", {63'd0, enable}, 64'd0);
        host_write(8'h02, 32'd36);
        check("casel36_err", {63'd0, wr_err}, 64'd1);
        @(posedge clk); #1;
        check("err_one_cycle", {63'd0, wr_err}, 64'd0);
        host_write(8'h57, 32'd1);
        check("addr57_err", {63'd0, wr_err}, 64'd1);
        host_write(8'h32, 32'd35);
        check("casel35_ok", {63'd0, wr_err}, 64'd0);
        host_write(8'hF1, 32'h0000_1234);
        host_write(8'hF0, 32'h2);
        check("casel0_unchanged", {58'd0, ca_sel[0]},   64'd0);
        check("casel3_written",   {58'd0, ca_sel[3]},   64'd35);
        check("noise_commit",     {48'd0, noise_gain},  64'h1234);
        check("idle_no_ramp",     {32'd0, freq[2]},     64'd3);

        // ---- async reset while PEND
        host_write(8'hF0, 32'h3);
        host_write(8'h00, 32'h0000_ABCD);
        host_write(8'hF0, 32'h3);
        check("pre_rst_pend", {63'd0, commit_pend}, 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("arst_enable",   {63'd0, enable},      64'd0);
        check("arst_wr_ready", {63'd0, wr_ready},    64'd1);
        check("arst_pend",     {63'd0, commit_pend}, 64'd0);
        check("arst_freq0",    {32'd0, freq[0]},     64'd0);
        check("arst_gain1",    {48'd0, gain[1]},     64'd0);
        check("arst_epochs",   {32'd0, epoch_count}, 64'd0);
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        host_write(8'hF0, 32'h2);
        check("lost_commit_freq0", {32'd0, freq[0]}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
